// File: rtl/fifo36_n_way_mux_pkg.sv
// Shared constants and types for the N-way fifo36 packet multiplexer.
package fifo36_pkg;

    localparam int SOF_BIT = 32;
    localparam int EOF_BIT = 33;
    localparam int MAX_CH  = 8;

    typedef enum logic {
        IDLE = 1'b0,
        PKT  = 1'b1
    } state_t;

endpackage

// File: rtl/fifo36_n_way_mux_if.sv
// Stream bundle between NUM_CH fifo36 sources, the mux and one downstream sink.
interface fifo36_n_way_mux_if #(
    parameter int NUM_CH = 3,
    parameter int WIDTH  = 36
);
    logic [NUM_CH*WIDTH-1:0] data_i;
    logic [NUM_CH-1:0]       src_rdy_i;
    logic [NUM_CH-1:0]       dst_rdy_o;
    logic [NUM_CH-1:0]       active_o;
    logic [WIDTH-1:0]        data_o;
    logic                    src_rdy_o;
    logic                    dst_rdy_i;

    modport master (
        output data_i, src_rdy_i, dst_rdy_i,
        input  dst_rdy_o, active_o, data_o, src_rdy_o
    );

    modport slave (
        input  data_i, src_rdy_i, dst_rdy_i,
        output dst_rdy_o, active_o, data_o, src_rdy_o
    );
endinterface

// File: rtl/fifo36_n_way_mux_rr_arbiter.sv
// Combinational channel picker: round-robin after last_i, or lowest index first.
module fifo36_rr_arbiter #(
    parameter  int NUM_CH = 3,
    parameter  int PRIO   = 0,
    localparam int IW     = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req_i,
    input  logic [IW-1:0]     last_i,
    output logic [NUM_CH-1:0] gnt_o,
    output logic [IW-1:0]     idx_o
);
    int   c;
    logic found;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        c     = 0;
        found = 1'b0;
        // Walk candidates in priority order; the first requester wins.
        for (int i = 1; i <= NUM_CH; i++) begin
            c = (PRIO != 0) ? (i - 1) : ((int'(last_i) + i) % NUM_CH);
            if (!found && req_i[c]) begin
                found    = 1'b1;
                gnt_o[c] = 1'b1;
                idx_o    = IW'(c);
            end
        end
    end
endmodule

// File: rtl/fifo36_n_way_mux.sv
// Packet-aware NUM_CH:1 fifo36 mux with registered output.
// Define FIFO36_N_WAY_STATS_EN to add per-channel completed-packet counters.
module fifo36_n_way_mux
    import fifo36_pkg::*;
#(
    parameter int NUM_CH = 3,
    parameter int WIDTH  = 36,
    parameter int PRIO   = 0
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    fifo36_n_way_mux_if.slave bus
`ifdef FIFO36_N_WAY_STATS_EN
    ,
    output logic [NUM_CH*16-1:0] pkt_cnt_o
`endif
);
    localparam int IW = $clog2(NUM_CH);

    state_t            state_q;
    logic [IW-1:0]     gnt_q, last_q;
    logic [WIDTH-1:0]  data_q;
    logic              vld_q, vld_d;

    logic [NUM_CH-1:0] arb_gnt, gnt_oh;
    logic [IW-1:0]     arb_idx;
    logic [WIDTH-1:0]  cur_word;
    logic              pass, acc, acc_eof;

    fifo36_rr_arbiter #(.NUM_CH(NUM_CH), .PRIO(PRIO)) u_arb (
        .req_i  (bus.src_rdy_i),
        .last_i (last_q),
        .gnt_o  (arb_gnt),
        .idx_o  (arb_idx)
    );

    always_comb begin
        gnt_oh        = '0;
        gnt_oh[gnt_q] = 1'b1;
    end

    assign cur_word = bus.data_i[gnt_q*WIDTH +: WIDTH];
    // Output slot can take a word if empty or draining this cycle.
    assign pass     = ~vld_q | bus.dst_rdy_i;
    assign acc      = (state_q == PKT) && bus.src_rdy_i[gnt_q] && pass;
    assign acc_eof  = acc && cur_word[EOF_BIT];
    assign vld_d    = acc | (vld_q & ~bus.dst_rdy_i);

    assign bus.dst_rdy_o = (state_q == PKT) ? (gnt_oh & {NUM_CH{pass}}) : '0;
    assign bus.active_o  = (state_q == PKT) ? gnt_oh : '0;
    assign bus.data_o    = data_q;
    assign bus.src_rdy_o = vld_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            last_q  <= IW'(NUM_CH - 1);
            data_q  <= '0;
            vld_q   <= 1'b0;
        end else if (clear) begin
            state_q <= IDLE;
            last_q  <= IW'(NUM_CH - 1);
            vld_q   <= 1'b0;
        end else begin
            vld_q <= vld_d;
            if (acc) data_q <= cur_word;
            case (state_q)
                IDLE: if (|arb_gnt) begin
                    gnt_q   <= arb_idx;
                    last_q  <= arb_idx;
                    state_q <= PKT;
                end
                PKT:  if (acc_eof) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef FIFO36_N_WAY_STATS_EN
    logic [NUM_CH-1:0][15:0] cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)       cnt_q <= '0;
        else if (clear)   cnt_q <= '0;
        else if (acc_eof) cnt_q[gnt_q] <= cnt_q[gnt_q] + 16'd1;
    end

    assign pkt_cnt_o = cnt_q;
`endif
endmodule
